// File: rtl/voting_pkg.sv
// Shared constants for the vote result reporter: frame layout, vote count
// width, FSM encodings and the frame checksum helper.
package voting_pkg;

  localparam int         VOTE_W        = 8;
  localparam logic [7:0] FRAME_HDR     = 8'hA5;
  localparam int         FRAME_BYTES   = 6;
  localparam logic [2:0] LAST_BYTE_IDX = 3'(FRAME_BYTES - 1);

  // Byte serialiser states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Frame sequencer states
  localparam logic [1:0] FR_IDLE = 2'd0;
  localparam logic [1:0] FR_SEND = 2'd1;
  localparam logic [1:0] FR_DONE = 2'd2;

  // XOR of the header and the four counts, sent as the trailing byte
  function automatic logic [7:0] frame_checksum(
    input logic [VOTE_W-1:0] c1,
    input logic [VOTE_W-1:0] c2,
    input logic [VOTE_W-1:0] c3,
    input logic [VOTE_W-1:0] c4
  );
    return FRAME_HDR ^ c1 ^ c2 ^ c3 ^ c4;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser. A start seen while idle, or on the final cycle of
// a stop bit, loads the byte immediately, so bytes can be chained back to back
// with no idle gap. tx is driven straight from a flop.
module uart_tx_byte
  import voting_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end_s;

  assign bit_end_s = (cnt_q == CNT_MAX);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_STOP) && bit_end_s;
  assign tx        = tx_q;

  // Next-state logic: baud counting, bit sequencing and line level
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_START;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          shift_d   = byte_in;
          tx_d      = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (start) begin
            state_d   = ST_START;
            bit_idx_d = 3'd0;
            shift_d   = byte_in;
            tx_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset forces the line high at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/vote_result_uart_tx.sv
// Vote result reporter: on a report request in result mode, snapshots the four
// candidate counts and sends A5, c1, c2, c3, c4, checksum over UART 8N1.
module vote_result_uart_tx
  import voting_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              report_req,
  input  logic [VOTE_W-1:0] cand1_votes,
  input  logic [VOTE_W-1:0] cand2_votes,
  input  logic [VOTE_W-1:0] cand3_votes,
  input  logic [VOTE_W-1:0] cand4_votes,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  logic [1:0]        fr_state_q, fr_state_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [VOTE_W-1:0] snap1_q, snap1_d, snap2_q, snap2_d;
  logic [VOTE_W-1:0] snap3_q, snap3_d, snap4_q, snap4_d;
  logic [7:0]        checksum_q, checksum_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic              accept_s;
  logic [2:0]        next_idx_s;
  logic [7:0]        next_byte_s;
  logic              ser_start_s;
  logic [7:0]        ser_byte_s;
  logic              ser_busy_s;
  logic              ser_done_s;

  assign accept_s   = (fr_state_q == FR_IDLE) && mode && report_req && !ser_busy_s;
  assign next_idx_s = byte_idx_q + 3'd1;

  // Byte mux: selects the frame byte that follows the one now on the line
  always_comb begin
    next_byte_s = FRAME_HDR;
    case (next_idx_s)
      3'd1:    next_byte_s = snap1_q;
      3'd2:    next_byte_s = snap2_q;
      3'd3:    next_byte_s = snap3_q;
      3'd4:    next_byte_s = snap4_q;
      3'd5:    next_byte_s = checksum_q;
      default: next_byte_s = FRAME_HDR;
    endcase
  end

  // Frame sequencer: accepts requests, feeds bytes, ends with a DONE cycle
  always_comb begin
    fr_state_d   = fr_state_q;
    byte_idx_d   = byte_idx_q;
    snap1_d      = snap1_q;
    snap2_d      = snap2_q;
    snap3_d      = snap3_q;
    snap4_d      = snap4_q;
    checksum_d   = checksum_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    ser_start_s  = 1'b0;
    ser_byte_s   = FRAME_HDR;
    case (fr_state_q)
      FR_IDLE: begin
        if (accept_s) begin
          snap1_d     = cand1_votes;
          snap2_d     = cand2_votes;
          snap3_d     = cand3_votes;
          snap4_d     = cand4_votes;
          checksum_d  = frame_checksum(cand1_votes, cand2_votes, cand3_votes, cand4_votes);
          byte_idx_d  = 3'd0;
          busy_d      = 1'b1;
          fr_state_d  = FR_SEND;
          ser_start_s = 1'b1;
          ser_byte_s  = FRAME_HDR;
        end else begin
          busy_d = 1'b0;
        end
      end
      FR_SEND: begin
        if (ser_done_s) begin
          if (byte_idx_q < LAST_BYTE_IDX) begin
            byte_idx_d  = next_idx_s;
            ser_start_s = 1'b1;
            ser_byte_s  = next_byte_s;
          end else begin
            fr_state_d   = FR_DONE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      FR_DONE: begin
        fr_state_d = FR_IDLE;
        busy_d     = 1'b0;
      end
      default: begin
        fr_state_d = FR_IDLE;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Sequencer, snapshot and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fr_state_q   <= FR_IDLE;
      byte_idx_q   <= 3'd0;
      snap1_q      <= '0;
      snap2_q      <= '0;
      snap3_q      <= '0;
      snap4_q      <= '0;
      checksum_q   <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fr_state_q   <= fr_state_d;
      byte_idx_q   <= byte_idx_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      snap3_q      <= snap3_d;
      snap4_q      <= snap4_d;
      checksum_q   <= checksum_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clock   (clock),
    .reset   (reset),
    .start   (ser_start_s),
    .byte_in (ser_byte_s),
    .busy    (ser_busy_s),
    .done    (ser_done_s),
    .tx      (tx)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
